lcd_frame_fetch_ctrl: RTL and testbench
=======================================

// Module: lcd_frame_fetch_ctrl
// PURPOSE
//  Sequences LCD pixel-FIFO writes: reads a frame buffer from memory via an Avalon-MM read master and feeds
//  the pixel FIFO's Avalon-ST sink (64b data, 3b empty, SOP/EOP). Runs in the FIFO write-clock domain.
//  Configured by a 4-register Avalon-MM slave; a credit scheme bounds in-flight reads so no returned
//  beat is ever dropped, whatever the FIFO's ready timing.
// PARAMETERS
//  ADDR_W       32  master address width (byte address)
//  DATA_W       64  beat width; fixed to the pixel FIFO data width
//  LEN_W        24  frame length counter width, in DATA_W beats
//  MAX_PENDING   8  max beats issued but not yet sent on src (power of 2, 2..32)
// PORTS
//  clk              in   1       system clock (= pixel FIFO wrclock)
//  reset_n          in   1       synchronous active-low reset
//  ctrl_address     in   2       0 CONTROL, 1 STATUS, 2 BASE, 3 LENGTH
//  ctrl_write       in   1       register write strobe
//  ctrl_writedata   in   32      write data
//  ctrl_read        in   1       register read strobe
//  ctrl_readdata    out  32      read data, valid 1 cycle after ctrl_read
//  irq              out  1       frame_done & irq_en
//  m_address        out  ADDR_W  beat address (low 3 bits always 0)
//  m_read           out  1       read request
//  m_waitrequest    in   1       slave stall
//  m_readdata       in   DATA_W  returned beat
//  m_readdatavalid  in   1       returned beat valid
//  src_data         out  DATA_W  to FIFO avalonst_sink_data
//  src_empty        out  3       always 0
//  src_sop          out  1       first beat of frame
//  src_eop          out  1       last beat of frame
//  src_valid        out  1       beat valid
//  src_ready        in   1       from FIFO avalonst_sink_ready
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; regs 0; counters/credits 0; response buffer empty.
//  Regs: CONTROL b0 go (self-clearing), b1 continuous, b2 irq_en. STATUS b0 busy (RO), b1 frame_done
//   (sticky, write-1-clear). BASE bits[2:0] ignored. LENGTH bits[LEN_W-1:0]. Reads return 0 in unused bits.
//  BASE/LENGTH writes go to shadow regs; latched into working regs only at frame start.
//  FSM: IDLE -go & LENGTH!=0-> FETCH (latch addr=BASE, issue_left=out_left=LENGTH). go with LENGTH==0: ignored.
//   FETCH -last read accepted-> DRAIN. DRAIN -last beat sent-> set frame_done;
//   then FETCH (relatch) if continuous && LENGTH!=0, else IDLE. go while busy ignored.
//  Issue: m_read=1 in FETCH only when credits<MAX_PENDING; m_address/m_read held stable while m_waitrequest.
//   Accept = m_read & !m_waitrequest -> credits+1, addr+=8, issue_left-1.
//  Return: m_readdatavalid pushes into response buffer (depth MAX_PENDING); cannot overflow since
//   credits count issued-but-unsent beats. Buffer head drives src_data; src_valid = !empty (show-ahead).
//  Send: src_valid & src_ready pops, credits-1, out_left-1. Accept and send same cycle: credits unchanged.
//  src_sop=1 when head is first beat of frame; src_eop=1 when out_left==1. LENGTH==1: sop & eop together.
//  src_data/sop/eop held stable while src_valid & !src_ready.
//  Address wraps modulo 2^ADDR_W silently. busy = FSM!=IDLE.
//  Clearing continuous mid-frame: current frame completes, then IDLE.
//  readdatavalid arriving while credits==0 (stale after reset) is discarded.
//  Reset mid-frame: immediate return to IDLE, buffer flushed, no frame_done, no partial EOP emitted.
// STRUCTURE
//  Package lcd_fetch_pkg: register offsets, CONTROL/STATUS bit indices, FSM state enum.
//  Sub-module lcd_fetch_resp_buf: sync show-ahead FIFO, DATA_W x MAX_PENDING, push/pop/empty/head.
//  Top holds FSM, credit counter, issue/out counters, register file.
// TESTING
//  BASE=0x1000, LENGTH=4, go, no stalls -> reads at 0x1000/08/10/18; 4 src beats, sop on beat0, eop on beat3;
//   frame_done=1, busy=0.
//  src_ready=0 held, LENGTH=64 -> exactly MAX_PENDING(8) reads accepted, then m_read=0 until src_ready=1.
//  m_waitrequest=1 for 5 cycles on 2nd read -> m_address=0x1008 stable throughout; order/data preserved.
//  LENGTH=1 -> one beat with sop=eop=1; LENGTH=0 + go -> no m_read, busy stays 0, frame_done stays 0.
//  continuous=1, LENGTH=3, rewrite BASE=0x2000 mid-frame -> frame1 from 0x1000, frame2 from 0x2000, no gap bubble
//   beyond FSM turnaround; clear continuous -> stops after frame2.
//  reset_n=0 mid-frame with 3 beats in flight -> outputs 0 next cycle; stale readdatavalid dropped; new go works.

Source files
------------

// File: rtl/lcd_fetch_pkg.sv
// Shared constants for the LCD frame fetch controller: register map,
// CONTROL/STATUS bit positions and the sequencing FSM states.
package lcd_fetch_pkg;

  // Register offsets on the ctrl slave (word addressed)
  localparam logic [1:0] RegControl = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegBase    = 2'd2;
  localparam logic [1:0] RegLength  = 2'd3;

  // CONTROL bits
  localparam int unsigned CtrlGoBit    = 0;
  localparam int unsigned CtrlContBit  = 1;
  localparam int unsigned CtrlIrqEnBit = 2;

  // STATUS bits
  localparam int unsigned StatBusyBit = 0;
  localparam int unsigned StatDoneBit = 1;

  // Byte stride between consecutive 64-bit beats
  localparam int unsigned BeatBytes = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/lcd_fetch_resp_buf.sv
// Show-ahead synchronous FIFO holding read beats returned by memory until the
// pixel FIFO accepts them. The head entry is visible whenever empty is low.
module lcd_fetch_resp_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  // Extra pointer bit distinguishes full from empty
  logic [PtrW:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                full;
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q[PtrW-1:0]];

  // Pointer update; reset flushes all buffered beats
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array needs no reset; pointers define which entries are live
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lcd_frame_fetch_ctrl.sv
// Frame fetch controller: reads a frame buffer through an Avalon-MM read
// master and streams it to the pixel FIFO sink. Credits count beats issued
// but not yet sent, so the response buffer can never overflow.
module lcd_frame_fetch_ctrl
  import lcd_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned LEN_W       = 24,
  parameter int unsigned MAX_PENDING = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  // Register slave
  input  logic [1:0]        ctrl_address,
  input  logic              ctrl_write,
  input  logic [31:0]       ctrl_writedata,
  input  logic              ctrl_read,
  output logic [31:0]       ctrl_readdata,
  output logic              irq,
  // Read master
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  // Stream source
  output logic [DATA_W-1:0] src_data,
  output logic [2:0]        src_empty,
  output logic              src_sop,
  output logic              src_eop,
  output logic              src_valid,
  input  logic              src_ready
);

  localparam int unsigned       CredW     = $clog2(MAX_PENDING) + 1;
  localparam logic [CredW-1:0]  CreditMax = CredW'(MAX_PENDING);
  localparam logic [LEN_W-1:0]  LenOne    = LEN_W'(1);

  fetch_state_e      state_q, state_d;

  // Register file (BASE/LENGTH are shadows, copied at frame start)
  logic              continuous_q, irq_en_q, frame_done_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  length_q;
  logic [ADDR_W-1:0] base_wdata;
  logic [31:0]       rd_mux, readdata_q;

  // Working frame state
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  issue_left_q, issue_left_d;
  logic [LEN_W-1:0]  out_left_q, out_left_d;
  logic              first_q, first_d;
  logic [CredW-1:0]  credits_q, credits_d;
  logic [CredW-1:0]  inflight_q, inflight_d;

  logic              wr_control, wr_status, wr_base, wr_length;
  logic              go, start, frame_end, busy;
  logic              accept, send, push;
  logic              buf_empty;
  logic [DATA_W-1:0] buf_head;

  assign wr_control = ctrl_write && (ctrl_address == RegControl);
  assign wr_status  = ctrl_write && (ctrl_address == RegStatus);
  assign wr_base    = ctrl_write && (ctrl_address == RegBase);
  assign wr_length  = ctrl_write && (ctrl_address == RegLength);
  assign go         = wr_control && ctrl_writedata[CtrlGoBit];
  assign base_wdata = ADDR_W'(ctrl_writedata);
  assign busy       = (state_q != StIdle);

  // Issue only while fewer than MAX_PENDING beats are unsent; once raised,
  // credits can only drop, so the request holds steady through waitrequest.
  assign m_read    = (state_q == StFetch) && (credits_q < CreditMax);
  assign m_address = addr_q;
  assign accept    = m_read & ~m_waitrequest;

  // Returns with no read outstanding are leftovers from before a reset
  assign push      = m_readdatavalid && (inflight_q != '0);

  assign src_valid = ~buf_empty;
  assign send      = src_valid & src_ready;
  assign src_data  = buf_empty ? '0 : buf_head;
  assign src_sop   = ~buf_empty & first_q;
  assign src_eop   = ~buf_empty & (out_left_q == LenOne);
  assign src_empty = 3'b000;

  assign irq           = frame_done_q & irq_en_q;
  assign ctrl_readdata = readdata_q;

  lcd_fetch_resp_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_PENDING)
  ) u_resp_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (m_readdata),
    .pop       (send),
    .empty     (buf_empty),
    .head      (buf_head)
  );

  // Frame sequencing: idle -> fetch (issue reads) -> drain (send remaining)
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go && (length_q != '0)) begin
          start   = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (accept && (issue_left_q == LenOne)) state_d = StDrain;
      end
      StDrain: begin
        if (send && (out_left_q == LenOne)) begin
          frame_end = 1'b1;
          if (continuous_q && (length_q != '0)) begin
            start   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Address/count next state; a restart overrides the final send's decrement
  always_comb begin
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    first_d      = first_q;
    credits_d    = credits_q + CredW'(accept) - CredW'(send);
    inflight_d   = inflight_q + CredW'(accept) - CredW'(push);
    if (start) begin
      addr_d       = base_q;
      issue_left_d = length_q;
      out_left_d   = length_q;
      first_d      = 1'b1;
    end else begin
      if (accept) begin
        addr_d       = addr_q + ADDR_W'(BeatBytes);
        issue_left_d = issue_left_q - LenOne;
      end
      if (send) begin
        out_left_d = out_left_q - LenOne;
        first_d    = 1'b0;
      end
    end
  end

  // FSM state, frame counters and credit tracking
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      first_q      <= 1'b0;
      credits_q    <= '0;
      inflight_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      first_q      <= first_d;
      credits_q    <= credits_d;
      inflight_q   <= inflight_d;
    end
  end

  // Register read decode; unused bits read as zero, go always reads zero
  always_comb begin
    rd_mux = '0;
    unique case (ctrl_address)
      RegControl: begin
        rd_mux[CtrlContBit]  = continuous_q;
        rd_mux[CtrlIrqEnBit] = irq_en_q;
      end
      RegStatus: begin
        rd_mux[StatBusyBit] = busy;
        rd_mux[StatDoneBit] = frame_done_q;
      end
      RegBase:   rd_mux = 32'(base_q);
      RegLength: rd_mux = 32'(length_q);
      default:   rd_mux = '0;
    endcase
  end

  // Register writes and registered read data; frame completion beats a clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      continuous_q <= 1'b0;
      irq_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      base_q       <= '0;
      length_q     <= '0;
      readdata_q   <= '0;
    end else begin
      if (wr_control) begin
        continuous_q <= ctrl_writedata[CtrlContBit];
        irq_en_q     <= ctrl_writedata[CtrlIrqEnBit];
      end
      if (wr_base)   base_q   <= {base_wdata[ADDR_W-1:3], 3'b000};
      if (wr_length) length_q <= ctrl_writedata[LEN_W-1:0];
      if (frame_end) begin
        frame_done_q <= 1'b1;
      end else if (wr_status && ctrl_writedata[StatDoneBit]) begin
        frame_done_q <= 1'b0;
      end
      readdata_q <= ctrl_read ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_lcd_frame_fetch_ctrl.sv
// Self-checking bench for lcd_frame_fetch_ctrl: a memory responder with
// optional stalls/latency, a stream sink with optional backpressure, and a
// frame model (base + 8*i addresses, sop on first, eop on last beat).
module tb_lcd_frame_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ctrl_address = '0;
  logic        ctrl_write = 1'b0;
  logic [31:0] ctrl_writedata = '0;
  logic        ctrl_read = 1'b0;
  logic [31:0] ctrl_readdata;
  logic        irq;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_waitrequest = 1'b0;
  logic [63:0] m_readdata = '0;
  logic        m_readdatavalid = 1'b0;
  logic [63:0] src_data;
  logic [2:0]  src_empty;
  logic        src_sop, src_eop, src_valid;
  logic        src_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  // Logs filled by the monitor, expectations filled by the model
  logic [31:0] pend[$];
  logic [31:0] acc_addr[$];
  int unsigned acc_cyc[$];
  logic [31:0] stall_addr[$];
  logic [63:0] obs_data[$];
  logic        obs_sop[$], obs_eop[$];
  int unsigned obs_cyc[$];
  logic [31:0] exp_addr[$];
  logic [63:0] exp_data[$];
  logic        exp_sop[$], exp_eop[$];

  // Responder/sink behaviour knobs
  bit          ret_hold = 0;
  bit          rand_lat = 0;
  bit          rand_wait = 0;
  int          ready_mode = 1;  // 0 never, 1 always, 2 random
  int          force_left = 0;
  logic [31:0] force_addr = '0;

  always #5 clk = ~clk;

  lcd_frame_fetch_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ctrl_address    (ctrl_address),
    .ctrl_write      (ctrl_write),
    .ctrl_writedata  (ctrl_writedata),
    .ctrl_read       (ctrl_read),
    .ctrl_readdata   (ctrl_readdata),
    .irq             (irq),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .src_data        (src_data),
    .src_empty       (src_empty),
    .src_sop         (src_sop),
    .src_eop         (src_eop),
    .src_valid       (src_valid),
    .src_ready       (src_ready)
  );

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a + 32'd77};
  endfunction

  // Observe handshakes with pre-edge values
  always @(posedge clk) begin
    cyc++;
    if (m_read && !m_waitrequest) begin
      acc_addr.push_back(m_address);
      acc_cyc.push_back(cyc);
      pend.push_back(m_address);
    end
    if (m_read && m_waitrequest) stall_addr.push_back(m_address);
    if (src_valid && src_ready) begin
      obs_data.push_back(src_data);
      obs_sop.push_back(src_sop);
      obs_eop.push_back(src_eop);
      obs_cyc.push_back(cyc);
    end
  end

  // Memory responder and sink ready, driven away from the active edge
  always @(negedge clk) begin
    if (pend.size() != 0 && !ret_hold && (!rand_lat || $urandom_range(0, 2) != 0)) begin
      m_readdatavalid = 1'b1;
      m_readdata      = mem_word(pend.pop_front());
    end else begin
      m_readdatavalid = 1'b0;
      m_readdata      = '0;
    end
    if (force_left != 0 && m_read && m_address == force_addr) begin
      m_waitrequest = 1'b1;
      force_left--;
    end else begin
      m_waitrequest = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    src_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    ctrl_address = a; ctrl_writedata = d; ctrl_write = 1'b1;
    @(negedge clk);
    ctrl_write = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    ctrl_address = a; ctrl_read = 1'b1;
    @(negedge clk);
    ctrl_read = 1'b0;
    d = ctrl_readdata;
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_cyc.delete(); stall_addr.delete();
    obs_data.delete(); obs_sop.delete(); obs_eop.delete(); obs_cyc.delete();
    exp_addr.delete(); exp_data.delete(); exp_sop.delete(); exp_eop.delete();
  endtask

  task automatic model_frame(input logic [31:0] base, input int len);
    logic [31:0] a;
    a = base & 32'hFFFF_FFF8;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(a);
      exp_data.push_back(mem_word(a));
      exp_sop.push_back(i == 0);
      exp_eop.push_back(i == len - 1);
      a = a + 32'd8;
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int c = 0; c < budget && obs_data.size() < n; c++) @(negedge clk);
  endtask

  task automatic start_frame(input logic [31:0] base, input int len, input logic [31:0] ctl);
    reg_write(2'd2, base);
    reg_write(2'd3, 32'(len));
    reg_write(2'd0, ctl);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({m_read, src_valid, src_sop, src_eop, irq} !== 5'b0 || src_data !== '0 ||
        m_address !== '0 || src_empty !== 3'b0) begin
      errors++;
      $display("FAIL reset_outputs got rd%b v%b sop%b eop%b irq%b data %h addr %h",
               m_read, src_valid, src_sop, src_eop, irq, src_data, m_address);
    end
    reset_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      reg_read(2'(r), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++; $display("FAIL reset_reg%0d got %h want 0", r, rd);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    clear_logs();
    model_frame(32'h1000, 4);
    start_frame(32'h1000, 4, 32'h1);
    wait_beats(4, 200);
    checks++;
    if (obs_data.size() != exp_data.size() || acc_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL basic_counts beats %0d want %0d reads %0d want %0d",
                         obs_data.size(), exp_data.size(), acc_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_data.size() && i < acc_addr.size() && i < exp_data.size(); i++) begin
      checks++;
      if ({obs_data[i], obs_sop[i], obs_eop[i]} !== {exp_data[i], exp_sop[i], exp_eop[i]} ||
          acc_addr[i] !== exp_addr[i]) begin
        errors++; $display("FAIL basic_beat%0d got %h %b%b @%h want %h %b%b @%h", i, obs_data[i],
                           obs_sop[i], obs_eop[i], acc_addr[i], exp_data[i], exp_sop[i],
                           exp_eop[i], exp_addr[i]);
      end
    end
    reg_read(2'd1, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++; $display("FAIL basic_status got %h want 00000002", rd);
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    reg_write(2'd2, 32'h0000_1237);
    reg_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0000_1230) begin
      errors++; $display("FAIL regs_base got %h want 00001230", rd);
    end
    reg_write(2'd3, 32'hFFFF_FFFF);
    reg_read(2'd3, rd);
    checks++;
    if (rd !== 32'h00FF_FFFF) begin
      errors++; $display("FAIL regs_length got %h want 00ffffff", rd);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL regs_irq_masked got %b want 0", irq);
    end
    reg_write(2'd0, 32'hFFFF_FFF6);
    reg_read(2'd0, rd);
    checks++;
    if (rd !== 32'h6 || irq !== 1'b1) begin
      errors++; $display("FAIL regs_control got %h irq %b want 00000006 irq 1", rd, irq);
    end
    reg_write(2'd1, 32'h2);
    reg_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL regs_w1c got %h irq %b want 0 irq 0", rd, irq);
    end
    reg_write(2'd0, 32'h0);
  endtask

  task automatic test_backpressure();
    clear_logs();
    ready_mode = 0;
    start_frame(32'h4000, 64, 32'h1);
    repeat (40) @(negedge clk);
    checks++;
    if (acc_addr.size() != 8 || m_read !== 1'b0) begin
      errors++; $display("FAIL bp_credit_limit reads %0d m_read %b want 8 and 0",
                         acc_addr.size(), m_read);
    end
    checks++;
    if (src_valid !== 1'b1 || src_sop !== 1'b1 || src_data !== mem_word(32'h4000)) begin
      errors++; $display("FAIL bp_head got v%b sop%b %h want v1 sop1 %h", src_valid, src_sop,
                         src_data, mem_word(32'h4000));
    end
    model_frame(32'h4000, 64);
    ready_mode = 2; rand_wait = 1; rand_lat = 1;
    wait_beats(64, 3000);
    rand_wait = 0; rand_lat = 0; ready_mode = 1;
    checks++;
    if (obs_data.size() != exp_data.size() || acc_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL bp_counts beats %0d want %0d reads %0d want %0d",
                         obs_data.size(), exp_data.size(), acc_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_data.size() && i < acc_addr.size() && i < exp_data.size(); i++) begin
      checks++;
      if ({obs_data[i], obs_sop[i], obs_eop[i]} !== {exp_data[i], exp_sop[i], exp_eop[i]} ||
          acc_addr[i] !== exp_addr[i]) begin
        errors++; $display("FAIL bp_beat%0d got %h %b%b @%h want %h %b%b @%h", i, obs_data[i],
                           obs_sop[i], obs_eop[i], acc_addr[i], exp_data[i], exp_sop[i],
                           exp_eop[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_waitrequest();
    clear_logs();
    model_frame(32'h1000, 6);
    force_addr = 32'h1008;
    force_left = 5;
    start_frame(32'h1000, 6, 32'h1);
    wait_beats(6, 300);
    checks++;
    if (stall_addr.size() != 5) begin
      errors++; $display("FAIL wait_stall_count got %0d want 5", stall_addr.size());
    end
    for (int i = 0; i < stall_addr.size(); i++) begin
      checks++;
      if (stall_addr[i] !== 32'h1008) begin
        errors++; $display("FAIL wait_addr_stable%0d got %h want 00001008", i, stall_addr[i]);
      end
    end
    checks++;
    if (obs_data.size() != exp_data.size() || acc_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL wait_counts beats %0d want %0d reads %0d want %0d",
                         obs_data.size(), exp_data.size(), acc_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_data.size() && i < acc_addr.size() && i < exp_data.size(); i++) begin
      checks++;
      if ({obs_data[i], obs_sop[i], obs_eop[i]} !== {exp_data[i], exp_sop[i], exp_eop[i]} ||
          acc_addr[i] !== exp_addr[i]) begin
        errors++; $display("FAIL wait_beat%0d got %h %b%b @%h want %h %b%b @%h", i, obs_data[i],
                           obs_sop[i], obs_eop[i], acc_addr[i], exp_data[i], exp_sop[i],
                           exp_eop[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_len_one_zero();
    logic [31:0] rd;
    reg_write(2'd1, 32'h2);
    clear_logs();
    model_frame(32'h5008, 1);
    start_frame(32'h5008, 1, 32'h1);
    wait_beats(1, 100);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_data.size() != 1 || acc_addr.size() != 1) begin
      errors++; $display("FAIL len1_counts beats %0d reads %0d want 1 and 1",
                         obs_data.size(), acc_addr.size());
    end else if ({obs_data[0], obs_sop[0], obs_eop[0], acc_addr[0]} !==
                 {exp_data[0], 1'b1, 1'b1, exp_addr[0]}) begin
      errors++; $display("FAIL len1_beat got %h %b%b @%h want %h 11 @%h", obs_data[0],
                         obs_sop[0], obs_eop[0], acc_addr[0], exp_data[0], exp_addr[0]);
    end
    reg_write(2'd1, 32'h2);
    clear_logs();
    start_frame(32'h6000, 0, 32'h1);
    repeat (20) @(negedge clk);
    reg_read(2'd1, rd);
    checks++;
    if (acc_addr.size() != 0 || stall_addr.size() != 0 || rd !== 32'h0) begin
      errors++; $display("FAIL len0_ignored reads %0d status %h want 0 and 00000000",
                         acc_addr.size(), rd);
    end
  endtask

  task automatic test_continuous();
    logic [31:0] rd;
    clear_logs();
    model_frame(32'h1000, 3);
    model_frame(32'h2000, 3);
    start_frame(32'h1000, 3, 32'h3);
    for (int c = 0; c < 100 && acc_addr.size() < 1; c++) @(negedge clk);
    reg_write(2'd2, 32'h2000);
    for (int c = 0; c < 100 && acc_addr.size() < 4; c++) @(negedge clk);
    reg_write(2'd0, 32'h0);
    wait_beats(6, 200);
    repeat (30) @(negedge clk);
    checks++;
    if (obs_data.size() != exp_data.size() || acc_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL cont_counts beats %0d want %0d reads %0d want %0d",
                         obs_data.size(), exp_data.size(), acc_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_data.size() && i < acc_addr.size() && i < exp_data.size(); i++) begin
      checks++;
      if ({obs_data[i], obs_sop[i], obs_eop[i]} !== {exp_data[i], exp_sop[i], exp_eop[i]} ||
          acc_addr[i] !== exp_addr[i]) begin
        errors++; $display("FAIL cont_beat%0d got %h %b%b @%h want %h %b%b @%h", i, obs_data[i],
                           obs_sop[i], obs_eop[i], acc_addr[i], exp_data[i], exp_sop[i],
                           exp_eop[i], exp_addr[i]);
      end
    end
    if (acc_cyc.size() > 3 && obs_cyc.size() > 2) begin
      checks++;
      if (acc_cyc[3] - obs_cyc[2] > 1) begin
        errors++; $display("FAIL cont_turnaround got %0d cycles want <= 1",
                           acc_cyc[3] - obs_cyc[2]);
      end
    end
    reg_read(2'd1, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++; $display("FAIL cont_stopped status %h want 00000002", rd);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    int valid_seen;
    reg_write(2'd1, 32'h2);
    clear_logs();
    ready_mode = 0;
    ret_hold = 1;
    start_frame(32'h6000, 16, 32'h1);
    for (int c = 0; c < 100 && acc_addr.size() < 3; c++) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_read, src_valid, src_sop, src_eop, irq} !== 5'b0 || m_address !== '0 ||
        src_data !== '0) begin
      errors++; $display("FAIL midreset_outputs got rd%b v%b sop%b eop%b addr %h data %h want 0",
                         m_read, src_valid, src_sop, src_eop, m_address, src_data);
    end
    ret_hold = 0;
    @(negedge clk);
    reset_n = 1'b1;
    valid_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (src_valid) valid_seen++;
    end
    checks++;
    if (valid_seen != 0 || m_read !== 1'b0) begin
      errors++; $display("FAIL midreset_stale valid cycles %0d m_read %b want 0 and 0",
                         valid_seen, m_read);
    end
    reg_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL midreset_status got %h want 00000000", rd);
    end
    clear_logs();
    ready_mode = 1;
    model_frame(32'h3000, 5);
    start_frame(32'h3000, 5, 32'h1);
    wait_beats(5, 200);
    checks++;
    if (obs_data.size() != exp_data.size() || acc_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL midreset_counts beats %0d want %0d reads %0d want %0d",
                         obs_data.size(), exp_data.size(), acc_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_data.size() && i < acc_addr.size() && i < exp_data.size(); i++) begin
      checks++;
      if ({obs_data[i], obs_sop[i], obs_eop[i]} !== {exp_data[i], exp_sop[i], exp_eop[i]} ||
          acc_addr[i] !== exp_addr[i]) begin
        errors++; $display("FAIL midreset_beat%0d got %h %b%b @%h want %h %b%b @%h", i,
                           obs_data[i], obs_sop[i], obs_eop[i], acc_addr[i], exp_data[i],
                           exp_sop[i], exp_eop[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] base, rd;
    int len;
    for (int it = 0; it < 4; it++) begin
      base = (it == 0) ? 32'hFFFF_FFE8 : $urandom;
      len  = $urandom_range(1, 20);
      reg_write(2'd1, 32'h2);
      clear_logs();
      model_frame(base, len);
      rand_wait = 1; rand_lat = 1; ready_mode = 2;
      start_frame(base, len, 32'h1);
      wait_beats(len, 2000);
      rand_wait = 0; rand_lat = 0; ready_mode = 1;
      checks++;
      if (obs_data.size() != exp_data.size() || acc_addr.size() != exp_addr.size()) begin
        errors++; $display("FAIL rand%0d_counts beats %0d want %0d reads %0d want %0d", it,
                           obs_data.size(), exp_data.size(), acc_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < obs_data.size() && i < acc_addr.size() && i < exp_data.size(); i++) begin
        checks++;
        if ({obs_data[i], obs_sop[i], obs_eop[i]} !== {exp_data[i], exp_sop[i], exp_eop[i]} ||
            acc_addr[i] !== exp_addr[i]) begin
          errors++; $display("FAIL rand%0d_beat%0d got %h %b%b @%h want %h %b%b @%h", it, i,
                             obs_data[i], obs_sop[i], obs_eop[i], acc_addr[i], exp_data[i],
                             exp_sop[i], exp_eop[i], exp_addr[i]);
        end
      end
      reg_read(2'd1, rd);
      checks++;
      if (rd !== 32'h2) begin
        errors++; $display("FAIL rand%0d_status got %h want 00000002", it, rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_regs();
    test_backpressure();
    test_waitrequest();
    test_len_one_zero();
    test_continuous();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
